// File: rtl/pipelined_divider_seq.sv
// ---------------------------------------------------------------------------
// pipelined_divider_seq
//
// Iterative unsigned restoring divider, one quotient bit per clock. It is the
// inverse companion of the 4x4 pipelined multiplier: an 8-bit product-width
// dividend is divided by a 4-bit divisor to give an 8-bit quotient and a
// 4-bit remainder.
//
// Ports
//   clk          system clock, all state updates on posedge
//   rst          synchronous reset, active-high, priority over everything
//   start        request, sampled only while busy=0
//   dividend     unsigned dividend, captured on accept
//   divisor      unsigned divisor, captured on accept
//   busy         high while an accepted division is iterating (CALC)
//   done         one-cycle pulse in FIN, result valid
//   quotient     registered quotient (all ones on divide-by-zero)
//   remainder    registered remainder (dividend LSBs on divide-by-zero)
//   div_by_zero  registered flag for the last result
//   o_dbg_state  current FSM state, for debug and checker binding
//
// Handshake: a request is accepted at any posedge where busy=0 and start=1.
// busy is low in IDLE and FIN, so a start held during the FIN cycle is taken
// on the FIN-exit edge with no idle gap. start while busy=1 is ignored and the
// inputs are not re-sampled. done is high for exactly the one FIN cycle; the
// result outputs change only on the edge entering FIN and hold until the
// next FIN.
// ---------------------------------------------------------------------------
module pipelined_divider_seq #(
   parameter int W_DIVIDEND = 8,
   parameter int W_DIVISOR  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [W_DIVIDEND-1:0] dividend,
   input  logic [W_DIVISOR-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [W_DIVIDEND-1:0] quotient,
   output logic [W_DIVISOR-1:0]  remainder,
   output logic                  div_by_zero,
   output logic [1:0]            o_dbg_state
);

   localparam int W_CNT = (W_DIVIDEND > 1) ? $clog2(W_DIVIDEND) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;

   logic [W_CNT-1:0]        r_cnt;
   logic [W_DIVISOR-1:0]    r_dvs;     // captured divisor
   logic [W_DIVIDEND-1:0]   r_dq;      // dividend bits shift out, quotient bits shift in
   logic [W_DIVISOR-1:0]    r_pr;      // partial remainder held between steps (always < divisor)
   logic [W_DIVIDEND-1:0]   r_quot;
   logic [W_DIVISOR-1:0]    r_rem;
   logic                    r_dz;

   logic                    w_accept;
   logic                    w_last;
   logic [W_DIVISOR:0]      w_shift;   // W_DIVISOR+1 bit working partial remainder
   logic [W_DIVISOR:0]      w_diff;
   logic                    w_neg;
   logic [W_DIVISOR:0]      w_pr_next;
   logic [W_DIVIDEND-1:0]   w_dq_next;

   // ------------------------------------------------------------------------
   // Datapath for one restoring step
   // ------------------------------------------------------------------------
   assign w_accept  = start && (r_state != CALC);
   assign w_last    = (r_cnt == '0);
   assign w_shift   = {r_pr, r_dq[W_DIVIDEND-1]};
   // The shifted value is below 2*divisor, so an unsigned compare is the
   // sign of the trial subtraction and the difference fits W_DIVISOR+1 bits.
   assign w_neg     = (w_shift < {1'b0, r_dvs});
   assign w_diff    = w_shift - {1'b0, r_dvs};
   assign w_pr_next = w_neg ? w_shift : w_diff;
   assign w_dq_next = {r_dq[W_DIVIDEND-2:0], ~w_neg};

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_next = (divisor == '0) ? FIN : CALC;
            end
         end
         CALC: begin
            if (w_last) begin
               w_state_next = FIN;
            end
         end
         FIN: begin
            if (start) begin
               w_state_next = (divisor == '0) ? FIN : CALC;
            end else begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Working registers and result registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_dvs  <= '0;
         r_dq   <= '0;
         r_pr   <= '0;
         r_quot <= '0;
         r_rem  <= '0;
         r_dz   <= 1'b0;
      end else if (w_accept) begin
         r_dvs <= divisor;
         r_dq  <= dividend;
         r_pr  <= '0;
         r_cnt <= W_CNT'(W_DIVIDEND - 1);
         if (divisor == '0) begin
            // Divide-by-zero skips CALC and publishes immediately.
            r_quot <= '1;
            r_rem  <= dividend[W_DIVISOR-1:0];
            r_dz   <= 1'b1;
         end
      end else if (r_state == CALC) begin
         r_pr  <= W_DIVISOR'(w_pr_next);
         r_dq  <= w_dq_next;
         r_cnt <= r_cnt - 1'b1;
         if (w_last) begin
            r_quot <= w_dq_next;
            r_rem  <= W_DIVISOR'(w_pr_next);
            r_dz   <= 1'b0;
         end
      end
   end

   // Outputs are decoded from registers only.
   assign busy        = (r_state == CALC);
   assign done        = (r_state == FIN);
   assign quotient    = r_quot;
   assign remainder   = r_rem;
   assign div_by_zero = r_dz;
   assign o_dbg_state = r_state;

endmodule
